// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller
// (master) and the instruction memory (slave).
interface pc_fetch_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Single-outstanding instruction fetch controller with delayed-branch
// redirect, exception/eret flush and a one-entry hold register.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000,
  parameter logic [31:0] EXC_PC   = 32'hbfc00380
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_target,
  input  logic                    exc_flush,
  input  logic                    eret,
  input  logic [31:0]             epc,
  pc_fetch_ctrl_if.master         ibus,
  output logic                    if_valid,
  output logic [31:0]             if_pc,
  output logic [31:0]             if_inst
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic        br_pend;
  logic [31:0] br_addr;
  logic        drop;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] next_seq_pc;

  always_comb begin
    redirect    = exc_flush | eret;
    redirect_pc = exc_flush ? EXC_PC : epc;
    next_seq_pc = br_pend ? br_addr : pc + 32'd4;
  end

  // Gated by rst so no request is visible during the reset cycle itself.
  assign ibus.inst_req  = (state == S_ADDR) && !rst;
  assign ibus.inst_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      br_pend  <= 1'b0;
      br_addr  <= '0;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_inst  <= '0;
    end else begin
      if (redirect) begin
        pc      <= redirect_pc;
        br_pend <= 1'b0;
      end else if (branch_taken) begin
        br_pend <= 1'b1;
        br_addr <= branch_target;
      end

      case (state)
        S_IDLE: state <= S_ADDR;
        S_ADDR: begin
          if (ibus.inst_addr_ok) begin
            state <= S_DATA;
            drop  <= redirect;
          end
        end
        S_DATA: begin
          if (ibus.inst_data_ok) begin
            if (drop || redirect) begin
              drop  <= 1'b0;
              state <= S_ADDR;
            end else begin
              if_valid <= 1'b1;
              if_pc    <= pc;
              if_inst  <= ibus.inst_rdata;
              state    <= S_HOLD;
            end
          end else if (redirect) begin
            drop <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            if_valid <= 1'b0;
            state    <= S_ADDR;
          end else if (!stall) begin
            if_valid <= 1'b0;
            state    <= S_ADDR;
            pc       <= next_seq_pc;
            // A branch arriving on the consuming cycle stays pending for the next exit.
            if (br_pend && !branch_taken) br_pend <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios plus randomized traffic checked
// by a transaction-level model of fetch order, delivery and redirects.
module tb_pc_fetch_ctrl;
  localparam logic [31:0] RST_PC = 32'hbfc00000;
  localparam logic [31:0] EXC_PC = 32'hbfc00380;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        exc_flush = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int total = 0;
  int bad = 0;
  int unsigned aok_rate = 100;
  int unsigned dok_rate = 100;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(.RESET_PC(RST_PC), .EXC_PC(EXC_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .exc_flush(exc_flush), .eret(eret), .epc(epc),
    .ibus(bus),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
  endfunction

  // Memory: one outstanding read, data at least one cycle after acceptance.
  logic        mem_out = 1'b0;
  logic [31:0] mem_addr = '0;

  always @(posedge clk) begin
    #1;
    bus.inst_addr_ok = ($urandom_range(99) < aok_rate);
    if (!rst && mem_out && ($urandom_range(99) < dok_rate)) begin
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = memfn(mem_addr);
    end else begin
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = $urandom;
    end
  end

  // Reference model: what should be fetched next, what is outstanding, what is held.
  logic        m_idle, m_valid, m_pend, m_out, m_kill, exp_req, redir;
  logic [31:0] m_next, m_tgt, m_addr, m_ifpc, m_ifinst, old_next;

  always @(negedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_valid = 1'b0; m_pend = 1'b0; m_out = 1'b0; m_kill = 1'b0;
      m_next = RST_PC; m_tgt = '0; m_addr = '0; m_ifpc = '0; m_ifinst = '0;
      mem_out = 1'b0;
    end else begin
      exp_req = !m_idle && !m_valid && !m_out;
      total++;
      if (bus.inst_req !== exp_req) begin
        bad++; $display("FAIL model_req: got %b want %b at %0t", bus.inst_req, exp_req, $time);
      end
      if (exp_req) begin
        total++;
        if (bus.inst_addr !== m_next) begin
          bad++; $display("FAIL model_addr: got %h want %h at %0t", bus.inst_addr, m_next, $time);
        end
      end
      total++;
      if (if_valid !== m_valid || if_pc !== m_ifpc || if_inst !== m_ifinst) begin
        bad++;
        $display("FAIL model_if: got v=%b pc=%h inst=%h want v=%b pc=%h inst=%h at %0t",
                 if_valid, if_pc, if_inst, m_valid, m_ifpc, m_ifinst, $time);
      end

      if (bus.inst_req && bus.inst_addr_ok) begin
        mem_out = 1'b1; mem_addr = bus.inst_addr;
      end else if (bus.inst_data_ok) begin
        mem_out = 1'b0;
      end

      redir    = exc_flush | eret;
      old_next = m_next;
      if (m_valid) begin
        if (redir) m_valid = 1'b0;
        else if (!stall) begin
          m_valid = 1'b0;
          m_next  = m_pend ? m_tgt : m_ifpc + 32'd4;
          m_pend  = 1'b0;
        end
      end else if (m_out && bus.inst_data_ok) begin
        m_out = 1'b0;
        if (!(m_kill || redir)) begin
          m_valid = 1'b1; m_ifpc = m_addr; m_ifinst = memfn(m_addr);
        end
      end
      if (redir) begin
        m_next = exc_flush ? EXC_PC : epc;
        m_pend = 1'b0;
        m_kill = 1'b1;
      end else if (branch_taken) begin
        m_pend = 1'b1; m_tgt = branch_target;
      end
      if (exp_req && bus.inst_addr_ok) begin
        m_out = 1'b1; m_addr = old_next; m_kill = redir;
      end
      m_idle = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; branch_taken = 1'b0; exc_flush = 1'b0; eret = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    aok_rate = 100; dok_rate = 100; stall = 1'b1;
    do_reset();
    repeat (6) @(negedge clk);
    total++;
    if (if_valid !== 1'b1) begin bad++; $display("FAIL reset_pre_valid: got %b want 1", if_valid); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0) begin
      bad++; $display("FAIL reset_if: got v=%b pc=%h inst=%h want 0/0/0", if_valid, if_pc, if_inst);
    end
    total++;
    if (bus.inst_req !== 1'b0 || bus.inst_addr !== RST_PC) begin
      bad++; $display("FAIL reset_bus: got req=%b addr=%h want 0/%h", bus.inst_req, bus.inst_addr, RST_PC);
    end
    stall = 1'b0;
  endtask

  task automatic test_basic();
    aok_rate = 100; dok_rate = 100; stall = 1'b0;
    do_reset();
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b0) begin bad++; $display("FAIL basic_idle: got req=%b want 0", bus.inst_req); end
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== RST_PC) begin
      bad++; $display("FAIL basic_first: got req=%b addr=%h want 1/%h", bus.inst_req, bus.inst_addr, RST_PC);
    end
    @(negedge clk);
    total++;
    if (if_valid !== 1'b0) begin bad++; $display("FAIL basic_data: got v=%b want 0", if_valid); end
    @(negedge clk);
    total++;
    if (if_valid !== 1'b1 || if_pc !== RST_PC || if_inst !== memfn(RST_PC)) begin
      bad++; $display("FAIL basic_deliver: got v=%b pc=%h inst=%h want 1/%h/%h",
                      if_valid, if_pc, if_inst, RST_PC, memfn(RST_PC));
    end
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00004) begin
      bad++; $display("FAIL basic_next: got req=%b addr=%h want 1/bfc00004", bus.inst_req, bus.inst_addr);
    end
  endtask

  task automatic test_stall();
    logic ok;
    logic [31:0] held;
    aok_rate = 100; dok_rate = 100; stall = 1'b1;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) begin ok = 1'b1; break; end
    end
    held = if_inst;
    total++;
    if (!ok) begin bad++; $display("FAIL stall_wait: got no if_valid want 1"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (if_valid !== 1'b1 || if_inst !== held || bus.inst_req !== 1'b0) begin
        bad++; $display("FAIL stall_hold: got v=%b inst=%h req=%b want 1/%h/0", if_valid, if_inst, bus.inst_req, held);
      end
    end
    @(posedge clk); #1 stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'hbfc00004) begin
      bad++; $display("FAIL stall_release: got req=%b addr=%h want 1/bfc00004", bus.inst_req, bus.inst_addr);
    end
  endtask

  task automatic test_branch();
    logic ok;
    aok_rate = 100; dok_rate = 100; stall = 1'b0;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.inst_req === 1'b1 && bus.inst_addr === 32'hbfc00008) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL branch_reach: got no request for bfc00008 want one"); end
    @(posedge clk); #1 branch_taken = 1'b1; branch_target = 32'hbfc00100;
    @(posedge clk); #1 branch_taken = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || if_pc !== 32'hbfc00008 || if_inst !== memfn(32'hbfc00008)) begin
      bad++; $display("FAIL branch_slot: got v=%b pc=%h want 1/bfc00008", if_valid, if_pc);
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.inst_req === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || bus.inst_addr !== 32'hbfc00100) begin
      bad++; $display("FAIL branch_target: got req=%b addr=%h want 1/bfc00100", ok, bus.inst_addr);
    end
  endtask

  task automatic test_exc();
    logic ok, seen_v;
    aok_rate = 100; dok_rate = 100; stall = 1'b0;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.inst_req === 1'b1 && bus.inst_addr === 32'hbfc00010) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL exc_reach: got no request for bfc00010 want one"); end
    dok_rate = 0;
    @(posedge clk); #1 exc_flush = 1'b1;
    @(negedge clk) dok_rate = 100;
    @(posedge clk); #1 exc_flush = 1'b0;
    ok = 1'b0; seen_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) seen_v = 1'b1;
      if (bus.inst_req === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (seen_v) begin bad++; $display("FAIL exc_drop: got if_valid=1 want 0"); end
    total++;
    if (!ok || bus.inst_addr !== EXC_PC) begin
      bad++; $display("FAIL exc_vector: got req=%b addr=%h want 1/%h", ok, bus.inst_addr, EXC_PC);
    end
  endtask

  task automatic test_priority();
    logic ok;
    aok_rate = 100; dok_rate = 100; stall = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) break;
    end
    @(posedge clk); #1 branch_taken = 1'b1; branch_target = 32'h12345678;
    @(posedge clk); #1
    exc_flush = 1'b1; eret = 1'b1; epc = 32'h80001000;
    branch_taken = 1'b1; branch_target = 32'h22220000; stall = 1'b0;
    @(posedge clk); #1 exc_flush = 1'b0; eret = 1'b0; branch_taken = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.inst_req === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || bus.inst_addr !== EXC_PC) begin
      bad++; $display("FAIL prio_vector: got req=%b addr=%h want 1/%h", ok, bus.inst_addr, EXC_PC);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) break;
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.inst_req === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || bus.inst_addr !== 32'hbfc00384) begin
      bad++; $display("FAIL prio_no_branch: got req=%b addr=%h want 1/bfc00384", ok, bus.inst_addr);
    end
  endtask

  task automatic test_wrap();
    logic ok;
    aok_rate = 100; dok_rate = 100; stall = 1'b0;
    do_reset();
    eret = 1'b1; epc = 32'hfffffffc;
    @(posedge clk); #1 eret = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || if_pc !== 32'hfffffffc || if_inst !== memfn(32'hfffffffc)) begin
      bad++; $display("FAIL wrap_deliver: got v=%b pc=%h want 1/fffffffc", if_valid, if_pc);
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.inst_req === 1'b1) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok || bus.inst_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_next: got req=%b addr=%h want 1/00000000", ok, bus.inst_addr);
    end
  endtask

  task automatic test_random();
    int unsigned deliveries;
    logic prev_v;
    deliveries = 0; prev_v = 1'b0;
    aok_rate = 70; dok_rate = 60; stall = 1'b0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (if_valid === 1'b1 && !prev_v) deliveries++;
      prev_v = if_valid;
      if (i % 200 == 0) begin
        aok_rate = $urandom_range(100, 20);
        dok_rate = $urandom_range(100, 20);
      end
      @(posedge clk); #1;
      stall         = ($urandom_range(2) == 0);
      branch_taken  = ($urandom_range(9) == 0);
      branch_target = ($urandom_range(7) == 0) ? 32'hfffffffc : ($urandom & 32'hfffffffc);
      exc_flush     = ($urandom_range(39) == 0);
      eret          = ($urandom_range(39) == 0);
      epc           = $urandom & 32'hfffffffc;
    end
    @(posedge clk); #1
    stall = 1'b0; branch_taken = 1'b0; exc_flush = 1'b0; eret = 1'b0;
    total++;
    if (deliveries < 20) begin
      bad++; $display("FAIL random_deliveries: got %0d want >=20", deliveries);
    end
  endtask

  initial begin
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    test_reset();
    test_basic();
    test_stall();
    test_branch();
    test_exc();
    test_priority();
    test_wrap();
    test_random();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc00000, the first fetch address after reset.
REQ-002 Parameter EXC_PC, default 32'hbfc00380, the exception-vector fetch address.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 stall  in  1  back end cannot accept the held instruction this cycle.
REQ-006 branch_taken  in  1  one-cycle pulse: redirect after the current (delay-slot) fetch.
REQ-007 branch_target  in  32  redirect address, sampled when branch_taken=1.
REQ-008 exc_flush  in  1  one-cycle pulse: kill in-flight fetch, fetch EXC_PC.
REQ-009 eret  in  1  one-cycle pulse: kill in-flight fetch, fetch epc.
REQ-010 epc  in  32  return address, sampled when eret=1.
REQ-011 inst_req  out  1  instruction-memory request valid.
REQ-012 inst_addr  out  32  request address; always equals the pc register.
REQ-013 inst_addr_ok  in  1  memory accepted the address this cycle.
REQ-014 inst_data_ok  in  1  read data valid this cycle.
REQ-015 inst_rdata  in  32  read data.
REQ-016 if_valid  out  1  if_pc/if_inst hold a fetched instruction.
REQ-017 if_pc  out  32  address of the held instruction.
REQ-018 if_inst  out  32  held instruction word.

Function
REQ-019 The FSM SHALL have states IDLE, ADDR, DATA and HOLD, plus registers pc, br_pend (1 bit), br_addr (32 bits) and drop (1 bit).
REQ-020 IDLE SHALL move to ADDR on the next cycle unconditionally.
REQ-021 ADDR SHALL drive inst_req=1 and SHALL move to DATA in any cycle with inst_addr_ok=1.
REQ-022 DATA SHALL drive inst_req=0 and SHALL ignore inst_addr_ok.
REQ-023 In DATA with inst_data_ok=1 and drop=0, the block SHALL latch if_pc<=pc, if_inst<=inst_rdata and if_valid<=1, and SHALL move to HOLD.
REQ-024 Latency SHALL be as follows: if_valid rises the cycle after inst_data_ok.
REQ-025 In DATA with inst_data_ok=1 and drop=1, the block SHALL clear drop, keep if_valid=0 and move to ADDR.
REQ-026 In HOLD, if_valid SHALL stay 1 and outputs SHALL stay stable while stall=1.
REQ-027 In HOLD with stall=0, the block SHALL clear if_valid and move to ADDR with the next pc:
  - br_addr if br_pend=1, which also clears br_pend;
  - otherwise pc+4, truncated to 32 bits (0xfffffffc wraps to 0x00000000).
REQ-028 The block SHALL issue no new request while in HOLD.
REQ-029 A branch_taken pulse SHALL set br_pend=1 and br_addr=branch_target in any state.
REQ-030 The branch redirect SHALL take effect at the next HOLD exit; the in-flight or held instruction is the delay slot and SHALL be delivered.
REQ-031 Redirect priority SHALL be exc_flush > eret > branch_taken, and the lower-priority input SHALL be ignored in the same cycle.
REQ-032 On exc_flush or eret, the block SHALL clear br_pend and load pc with EXC_PC or epc respectively, then act by state:
  - IDLE: the FSM moves to ADDR;
  - ADDR: the FSM stays in ADDR and inst_addr changes next cycle (unaccepted address may change);
  - DATA: drop<=1 and the FSM stays in DATA; if inst_data_ok=1 in the same cycle, that data is discarded and the FSM moves to ADDR with drop=0;
  - HOLD: if_valid<=0 and the FSM moves to ADDR, regardless of stall.
REQ-033 An exc_flush or eret arriving in ADDR in the same cycle as inst_addr_ok SHALL set drop=1 and move the FSM to DATA.
REQ-034 At most one request SHALL be outstanding at any time.

Reset
REQ-035 While rst=1, the block SHALL set pc=RESET_PC, state=IDLE, inst_req=0, if_valid=0, if_pc=0, if_inst=0, br_pend=0, br_addr=0 and drop=0.
REQ-036 rst SHALL override all other inputs, including during an outstanding request.
REQ-037 After reset, a data_ok belonging to a pre-reset request is undefined; the memory model SHALL be reset together with this block.

Verification
REQ-038 Reset release with addr_ok=1 and data_ok one cycle later:
  - inst_addr=0xbfc00000 on the first request;
  - if_valid=1 with if_pc=0xbfc00000 two cycles after acceptance;
  - with stall=0, the next inst_addr is 0xbfc00004.
REQ-039 stall held 3 cycles while in HOLD: if_valid and if_inst stay stable for those 3 cycles and inst_req stays 0.
REQ-040 Branch: branch_taken with target 0xbfc00100 while fetching 0xbfc00008 in DATA:
  - 0xbfc00008 is delivered;
  - the next request is 0xbfc00100.
REQ-041 Exception in DATA: exc_flush while 0xbfc00010 is outstanding:
  - the returning data is dropped, with if_valid staying 0;
  - the next inst_addr is 0xbfc00380.
REQ-042 Same-cycle priority: exc_flush, eret (epc=0x80001000) and branch_taken in one cycle:
  - the next fetch is 0xbfc00380;
  - br_pend=0.
REQ-043 Wrap-around: pc=0xfffffffc delivered, then stall=0 gives next inst_addr=0x00000000.
